// File: rtl/shift_add_multiplier4bit.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Each RUN cycle the carry-select adder adds either mcand or zero to the
// high half of the accumulator, and the full {cout, sum, acc_lo} word is
// shifted right by one bit. The multiplier operand starts in acc_lo and is
// consumed from its LSB as the product bits shift in from the top.

// 4-bit carry-select adder: the low pair ripples, and the high pair is
// computed for both carry-in values, then one result is selected.
module carry_select_adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

    assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    assign cout = lo[2] ? hi1[2] : hi0[2];
endmodule

module shift_add_multiplier4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = acc_lo[0] ? mcand : '0;

    carry_select_adder4bit u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // One-bit right shift of {cout, sum, acc_lo}; the adder carry lands in
    // the MSB so no partial-product bit is ever lost.
    assign next_hi = {cout, sum[WIDTH-1:1]};
    assign next_lo = {sum[0], acc_lo[WIDTH-1:1]};

    // Both status outputs decode directly from the registered state.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Control FSM and accumulator datapath; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= A;
                        acc_lo <= B;
                        acc_hi <= '0;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product <= {next_hi, next_lo};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
